imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-port arbiter and fetch sequencer in front of the combinational instruction ROM (`imem`). It shares the single ROM read port between the processor fetch port (port 0) and a debug/trace read port (port 1) using a round-robin grant. It registers the ROM address and the returned instruction, so both requesters see a fixed-latency, fully pipelined read with one-read-per-cycle throughput. It also flags out-of-range addresses and counts fetch-port stall cycles.

## Interface
- `IMEM_WORDS`, default 19: number of populated ROM words. Word addresses >= this value are out of range.
- `CNT_W`, default 16: width of the stall counter.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  fetch port request.
- `req0_addr`  in  6  fetch word address.
- `req0_ready`  out  1  fetch request accepted this cycle.
- `rsp0_valid`  out  1  fetch response, one-cycle pulse.
- `rsp0_data`  out  32  fetch instruction.
- `rsp0_err`  out  1  fetch address was out of range.
- `req1_valid`, `req1_addr`, `req1_ready`, `rsp1_valid`, `rsp1_data`, `rsp1_err`: same widths and meanings, for the debug port.
- `mem_addr`  out  6  word address to `imem.addr`; driven from a register.
- `mem_instr`  in  32  from `imem.instr`; combinational with respect to `mem_addr`.
- `stall0_cnt`  out  CNT_W  saturating count of cycles with `req0_valid && !req0_ready`.

## Operation
- **Handshake.** A request transfers on a cycle where `valid && ready`. Once `valid` is asserted, it stays high and `addr` stays stable until that cycle. Responses have no backpressure.
- **Grant.** At most one `ready` is high per cycle. Each `ready` is combinational from both `valid` inputs and the `last` pointer.
  - Only one port valid: that port is granted.
  - Both ports valid: the port that is not `last` is granted.
  - `last` updates to the granted port on every grant and holds otherwise.
- **Stage A (address).** On a grant, register:
  - `mem_addr` <= the granted address;
  - `a_vld` <= 1;
  - `a_port` <= the granted port;
  - `a_err` <= (address >= `IMEM_WORDS`).
  
  With no grant, `a_vld` <= 0 and `mem_addr` holds.
- **Stage B (data).** When `a_vld` is set:
  - `rsp<a_port>_valid` <= 1;
  - `rsp<a_port>_data` <= `a_err` ? 0 : `mem_instr`;
  - `rsp<a_port>_err` <= `a_err`.
  
  The other port's `rsp_valid` <= 0. Data and err registers hold their values when not loaded.
- **Stall counter.** `stall0_cnt` increments by 1 on each cycle with `req0_valid && !req0_ready`. It saturates at all-ones.
- **Reset values** (all outputs and state):
  - `last` = 1, so port 0 wins the first conflict;
  - `a_vld` = 0, `mem_addr` = 0;
  - all `rsp*_valid`, `rsp*_data`, `rsp*_err` = 0;
  - `stall0_cnt` = 0.

  `ready` outputs are 0 while `reset_n` is low.
- **Reset mid-operation.** In-flight requests in stage A or B are discarded and produce no response. After release, the first grant behaves as after power-up.

## Timing
- **Latency.** A request accepted in cycle N produces its `rsp_valid` pulse in cycle N+2 (two registers on the path).
- **Throughput.** One grant per cycle. Back-to-back grants yield back-to-back responses, in grant order.
- **Conflicts.**
  - Both ports held valid continuously: grants alternate 0,1,0,1…, and each port gets one response every 2 cycles.
  - A single requester held valid: it is granted every cycle.
- **Address path.** `mem_addr` changes only on a clock edge. Stage B samples `mem_instr` one cycle after `mem_addr` changes. The ROM path is a full cycle.
- **Boundaries.**
  - Address `IMEM_WORDS-1` is in range.
  - Address `IMEM_WORDS` through 63 are out of range: `err`=1, `data`=0. They still consume a grant and keep 2-cycle latency.
  - `stall0_cnt` at 2^CNT_W−1 stays there.

## Structure
- **Package `imem_arb_pkg`:**
  - `port_id_t` (1-bit enum: `PORT_FETCH`=0, `PORT_DBG`=1);
  - `waddr_t` (`logic [5:0]`);
  - `instr_t` (`logic [31:0]`);
  - default `IMEM_WORDS` localparam.
- **Sub-module `rr_arb2`:** two-request round-robin grant. It holds the `last` register and produces one-hot grants. The pipeline registers and counter stay in `imem_arbiter`.
- `imem` is instantiated beside the block in the bench and top-level, not inside it.

## Test plan
- **Single fetch.** Port 0 requests addr 0x00 in cycle 1 → `req0_ready`=1 in cycle 1; `rsp0_valid`=1 with data 0x20020005, err 0, in cycle 3.
- **Streaming fetch.** Port 0 holds valid and steps addr 0x10, 0x11, 0x12 → responses 0xac020054 and 0x08000012 on consecutive cycles, in order. (Addr 0x10 returns 0x20020001.)
- **Conflict.** Both ports valid from reset, port 0 addr 0x01, port 1 addr 0x02 → grants port0, port1, port0, …
  - port 0 receives 0x2003000c;
  - port 1 receives 0x2067fff7;
  - `stall0_cnt` increments on each port-1 grant cycle.
- **Out of range.** Port 1 addr 0x13 with `IMEM_WORDS`=19 → `rsp1_valid`=1, err 1, data 0 at N+2. Addr 0x12 on the same port → err 0.
- **Reset mid-flight.** Grant port 0 at cycle N, pulse `reset_n` low during N+1 → no `rsp0_valid` at N+2, and all outputs equal their reset values. The next conflict grants port 0 first.
- **Counter saturation.** With `CNT_W`=4, hold port 0 stalled for 20 cycles (port 1 granted on alternate cycles) → `stall0_cnt` stops at 15.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-ROM arbiter.
// Port identifiers, word-address and instruction types, and the default populated ROM depth.
package imem_arb_pkg;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DBG   = 1'b1
  } port_id_t;

  typedef logic [5:0]  waddr_t;
  typedef logic [31:0] instr_t;

  localparam int unsigned IMEM_WORDS_DEFAULT = 19;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter with one-hot grant.
// Holds the port that was granted most recently; no grant is issued while reset is asserted.
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_id_t last_q, last_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= PORT_DBG;  // port 0 wins the first conflict
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (reset_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == PORT_DBG) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = PORT_FETCH;
    end else if (gnt[1]) begin
      last_d = PORT_DBG;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one combinational instruction ROM between a fetch port and a debug port.
// Two-stage pipeline (address, data) gives a fixed two-cycle latency at one read per cycle.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [5:0]       req0_addr,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_data,
  output logic             rsp0_err,
  input  logic             req1_valid,
  input  logic [5:0]       req1_addr,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_data,
  output logic             rsp1_err,
  output logic [5:0]       mem_addr,
  input  logic [31:0]      mem_instr,
  output logic [CNT_W-1:0] stall0_cnt
);

  logic [1:0] gnt;
  waddr_t     gnt_addr;
  port_id_t   gnt_port;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1_valid, req0_valid}),
    .gnt     (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign gnt_addr   = gnt[1] ? req1_addr : req0_addr;
  assign gnt_port   = gnt[1] ? PORT_DBG : PORT_FETCH;

  // Stage A: registered ROM address and request tag
  waddr_t   mem_addr_q;
  logic     a_vld_q, a_err_q;
  port_id_t a_port_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q <= '0;
      a_vld_q    <= 1'b0;
      a_port_q   <= PORT_FETCH;
      a_err_q    <= 1'b0;
    end else begin
      a_vld_q <= |gnt;
      if (|gnt) begin
        mem_addr_q <= gnt_addr;
        a_port_q   <= gnt_port;
        a_err_q    <= (32'(gnt_addr) >= IMEM_WORDS);
      end
    end
  end

  assign mem_addr = mem_addr_q;

  // Stage B: per-port response registers; data/err hold when not loaded
  logic   rsp0_valid_q, rsp1_valid_q, rsp0_err_q, rsp1_err_q;
  instr_t rsp0_data_q, rsp1_data_q, b_data;
  logic   ld0, ld1;

  assign b_data = a_err_q ? '0 : mem_instr;
  assign ld0    = a_vld_q && (a_port_q == PORT_FETCH);
  assign ld1    = a_vld_q && (a_port_q == PORT_DBG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
    end else begin
      rsp0_valid_q <= ld0;
      rsp1_valid_q <= ld1;
      if (ld0) begin
        rsp0_data_q <= b_data;
        rsp0_err_q  <= a_err_q;
      end
      if (ld1) begin
        rsp1_data_q <= b_data;
        rsp1_err_q  <= a_err_q;
      end
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp1_err   = rsp1_err_q;

  // Saturating count of fetch-port stall cycles
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (req0_valid && !req0_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall0_cnt = cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised and directed bench for imem_arbiter against a transaction-level model.
// The model tracks grants by the round-robin rule and schedules each response two cycles later.
module tb_imem_arbiter;

  localparam int unsigned WORDS = 19;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [5:0]    req0_addr = '0, req1_addr = '0;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0]   rsp0_data, rsp1_data;
  logic [5:0]    mem_addr;
  logic [31:0]   mem_instr;
  logic [CW-1:0] stall0_cnt;

  logic [31:0] rom [0:63];

  always #5 clk = ~clk;

  // ROM beside the arbiter; unpopulated words return junk so the err path must zero it
  always_comb mem_instr = rom[mem_addr];

  imem_arbiter #(
    .IMEM_WORDS (WORDS),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_err   (rsp1_err),
    .mem_addr   (mem_addr),
    .mem_instr  (mem_instr),
    .stall0_cnt (stall0_cnt)
  );

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          m_last;
  logic [5:0]  m_addr;
  int          m_cnt;
  logic        exp_vld [2];
  logic [31:0] exp_data [2];
  logic        exp_err [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = 1;
    m_addr = '0;
    m_cnt  = 0;
    for (int p = 0; p < 2; p++) begin
      exp_vld[p]  = 1'b0;
      exp_data[p] = '0;
      exp_err[p]  = 1'b0;
    end
  endtask

  // One cycle: drive inputs at the falling edge, check, then advance the model
  task automatic step(input logic v0, input logic [5:0] a0, input logic v1,
                      input logic [5:0] a1, input logic rst, output int g);
    exp_t e;
    int   max_cnt;
    max_cnt = (1 << CW) - 1;
    g = -1;
    @(negedge clk);
    reset_n    = !rst;
    req0_valid = v0;
    req0_addr  = a0;
    req1_valid = v1;
    req1_addr  = a1;
    #1;
    if (rst) begin
      model_reset();
    end else begin
      exp_vld[0] = 1'b0;
      exp_vld[1] = 1'b0;
      while (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        exp_vld[e.port]  = 1'b1;
        exp_data[e.port] = e.data;
        exp_err[e.port]  = e.err;
      end
      if (v0 && v1) g = (m_last == 1) ? 0 : 1;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    check("rsp0_valid", rsp0_valid, exp_vld[0]);
    check("rsp1_valid", rsp1_valid, exp_vld[1]);
    check("rsp0_data", rsp0_data, exp_data[0]);
    check("rsp1_data", rsp1_data, exp_data[1]);
    check("rsp0_err", rsp0_err, exp_err[0]);
    check("rsp1_err", rsp1_err, exp_err[1]);
    check("mem_addr", mem_addr, m_addr);
    check("stall0_cnt", stall0_cnt, m_cnt);
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    if (!rst) begin
      if (g >= 0) begin
        e.due  = cyc + 2;
        e.port = g;
        e.err  = ((g == 0) ? a0 : a1) >= WORDS;
        e.data = e.err ? 32'h0 : rom[(g == 0) ? a0 : a1];
        q.push_back(e);
        m_last = g;
        m_addr = (g == 0) ? a0 : a1;
      end
      if (v0 && g != 0 && m_cnt < max_cnt) m_cnt++;
    end
    cyc++;
  endtask

  int         g;
  logic       pend0, pend1;
  logic [5:0] pa0, pa1;

  initial begin
    rom[0]  = 32'h20020005; rom[1]  = 32'h2003000c; rom[2]  = 32'h2067fff7;
    rom[3]  = 32'h00e22025; rom[4]  = 32'h00642824; rom[5]  = 32'h00a42820;
    rom[6]  = 32'h10a7000a; rom[7]  = 32'h0064202a; rom[8]  = 32'h10800001;
    rom[9]  = 32'h20050000; rom[10] = 32'h00e2202a; rom[11] = 32'h00853820;
    rom[12] = 32'h00e23822; rom[13] = 32'hac670044; rom[14] = 32'h8c020050;
    rom[15] = 32'h08000011; rom[16] = 32'h20020001; rom[17] = 32'hac020054;
    rom[18] = 32'h08000012;
    for (int i = 19; i < 64; i++) rom[i] = 32'hdead0000 | 32'(i);
    model_reset();

    step(0, 0, 0, 0, 1, g);
    step(0, 0, 0, 0, 1, g);

    // Single fetch of word 0
    step(1, 6'h00, 0, 0, 0, g);
    repeat (3) step(0, 0, 0, 0, 0, g);

    // Streaming fetch 0x10..0x12
    step(1, 6'h10, 0, 0, 0, g);
    step(1, 6'h11, 0, 0, 0, g);
    step(1, 6'h12, 0, 0, 0, g);
    repeat (3) step(0, 0, 0, 0, 0, g);

    // Conflict from reset: expect alternating grants starting with port 0
    step(0, 0, 0, 0, 1, g);
    for (int i = 0; i < 8; i++) begin
      step(1, 6'h01, 1, 6'h02, 0, g);
      check("conflict_grant", g, i % 2);
    end
    repeat (3) step(0, 0, 0, 0, 0, g);

    // Out-of-range boundary on the debug port
    step(0, 0, 1, 6'h13, 0, g);
    step(0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, g);
    check("oor_err", rsp1_err, 1'b1);
    step(0, 0, 1, 6'h12, 0, g);
    step(0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, g);
    check("inrange_data", rsp1_data, 32'h08000012);
    step(0, 0, 1, 6'h3f, 0, g);
    repeat (3) step(0, 0, 0, 0, 0, g);

    // Reset while a fetch is in flight; next conflict grants port 0 first
    step(1, 6'h05, 1, 6'h06, 0, g);
    step(1, 6'h05, 0, 0, 0, g);
    step(0, 0, 0, 0, 1, g);
    step(0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, g);
    step(1, 6'h07, 1, 6'h08, 0, g);
    check("post_reset_first", g, 0);
    repeat (3) step(0, 0, 0, 0, 0, g);

    // Stall counter saturation
    step(0, 0, 0, 0, 1, g);
    repeat (40) step(1, 6'h03, 1, 6'h04, 0, g);
    check("stall_sat", stall0_cnt, 4'hf);
    repeat (3) step(0, 0, 0, 0, 0, g);

    // Random traffic obeying the valid/ready hold rule, with occasional resets
    pend0 = 1'b0;
    pend1 = 1'b0;
    pa0   = '0;
    pa1   = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!pend0 && ($urandom % 3 != 0)) begin
        pend0 = 1'b1;
        pa0 = ($urandom % 5 == 0) ? 6'($urandom_range(19, 63)) : 6'($urandom_range(0, 18));
      end
      if (!pend1 && ($urandom % 2 == 0)) begin
        pend1 = 1'b1;
        pa1 = ($urandom % 4 == 0) ? 6'($urandom_range(19, 63)) : 6'($urandom_range(0, 18));
      end
      if ($urandom % 150 == 0) begin
        step(pend0, pa0, pend1, pa1, 1, g);
        pend0 = 1'b0;
        pend1 = 1'b0;
      end else begin
        step(pend0, pa0, pend1, pa1, 0, g);
        if (g == 0) pend0 = 1'b0;
        if (g == 1) pend1 = 1'b0;
      end
    end
    repeat (3) step(0, 0, 0, 0, 0, g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
